// File: rtl/i2c_rx_ball_loader_if.sv
// Bundles the I2C slave register file, ball handshake and status outputs of the loader.
interface i2c_rx_ball_loader_if;
    logic       is_slave_done;
    logic [7:0] i_y_pos0;
    logic [7:0] i_y_pos1;
    logic [7:0] i_y_vel;
    logic [7:0] i_gravity;
    logic [7:0] i_is_collusion;
    logic [7:0] i_is_win_flag;
    logic       ball_ack;
    logic       ball_valid;
    logic [9:0] ball_y;
    logic [7:0] ball_vy;
    logic [1:0] gravity_counter;
    logic       is_collusion;
    logic       is_win;
    logic       frame_err;
    logic       frame_drop;
    logic [7:0] err_count;
    logic       busy;

    modport master (
        output is_slave_done, i_y_pos0, i_y_pos1, i_y_vel, i_gravity, i_is_collusion,
               i_is_win_flag, ball_ack,
        input  ball_valid, ball_y, ball_vy, gravity_counter, is_collusion, is_win,
               frame_err, frame_drop, err_count, busy
    );

    modport slave (
        input  is_slave_done, i_y_pos0, i_y_pos1, i_y_vel, i_gravity, i_is_collusion,
               i_is_win_flag, ball_ack,
        output ball_valid, ball_y, ball_vy, gravity_counter, is_collusion, is_win,
               frame_err, frame_drop, err_count, busy
    );
endinterface

// File: rtl/i2c_rx_ball_loader.sv
// Captures an I2C-delivered ball frame on slave_done, validates it and presents it to the
// game logic with a valid/ack handshake, ack timeout and saturating error count.
module i2c_rx_ball_loader #(
    parameter int unsigned Y_MAX       = 479,
    parameter int unsigned ACK_TIMEOUT = 1_000_000
) (
    input logic                  clk,
    input logic                  reset,
    i2c_rx_ball_loader_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StCapture, StCheck, StPresent} state_e;

    state_e      state_q, state_d;
    logic        done_q;
    logic        armed_q;
    logic [7:0]  y0_q, y1_q, vel_q, grav_q, coll_q, win_q;
    logic [31:0] cnt_q, cnt_d;
    logic        valid_q, valid_d;
    logic [9:0]  y_q;
    logic [7:0]  vy_q;
    logic [1:0]  gc_q;
    logic        coll_out_q, win_out_q;
    logic [7:0]  err_q, err_d;

    logic        rise, legal, overrun, acked, timeout, frame_err, load;
    logic [9:0]  hold_y;
    logic [1:0]  err_inc;
    logic [8:0]  err_sum;

    // armed_q keeps a level already high at reset release from looking like a new frame
    assign rise    = armed_q & ~done_q & bus.is_slave_done;
    assign hold_y  = {y0_q[1:0], y1_q};
    assign legal   = (y0_q[7:2] == 6'd0) && ({22'd0, hold_y} <= Y_MAX) &&
                     (grav_q[7:2] == 6'd0) && (coll_q <= 8'd1) && (win_q <= 8'd1);
    assign overrun = rise && (state_q != StIdle);
    assign acked   = valid_q & bus.ball_ack;
    assign timeout = (state_q == StPresent) && !acked && (cnt_q == ACK_TIMEOUT - 32'd1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        valid_d   = valid_q;
        frame_err = 1'b0;
        load      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rise) state_d = StCapture;
            end
            StCapture: state_d = StCheck;
            StCheck: begin
                if (legal) begin
                    load    = 1'b1;
                    valid_d = 1'b1;
                    cnt_d   = 32'd0;
                    state_d = StPresent;
                end else begin
                    frame_err = 1'b1;
                    state_d   = StIdle;
                end
            end
            StPresent: begin
                cnt_d = cnt_q + 32'd1;
                if (acked || timeout) begin
                    valid_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Timeout and overrun in the same cycle are two distinct causes: count both
    always_comb begin
        err_inc = {1'b0, frame_err} + {1'b0, overrun} + {1'b0, timeout};
        err_sum = {1'b0, err_q} + {7'd0, err_inc};
        err_d   = err_sum[8] ? 8'hFF : err_sum[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            done_q     <= 1'b0;
            armed_q    <= 1'b0;
            y0_q       <= 8'd0;
            y1_q       <= 8'd0;
            vel_q      <= 8'd0;
            grav_q     <= 8'd0;
            coll_q     <= 8'd0;
            win_q      <= 8'd0;
            cnt_q      <= 32'd0;
            valid_q    <= 1'b0;
            y_q        <= 10'd0;
            vy_q       <= 8'd0;
            gc_q       <= 2'd0;
            coll_out_q <= 1'b0;
            win_out_q  <= 1'b0;
            err_q      <= 8'd0;
        end else begin
            state_q <= state_d;
            done_q  <= bus.is_slave_done;
            armed_q <= 1'b1;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            if (state_q == StCapture) begin
                y0_q   <= bus.i_y_pos0;
                y1_q   <= bus.i_y_pos1;
                vel_q  <= bus.i_y_vel;
                grav_q <= bus.i_gravity;
                coll_q <= bus.i_is_collusion;
                win_q  <= bus.i_is_win_flag;
            end
            if (load) begin
                y_q        <= hold_y;
                vy_q       <= vel_q;
                gc_q       <= grav_q[1:0];
                coll_out_q <= coll_q[0];
                win_out_q  <= win_q[0];
            end
        end
    end

    assign bus.ball_valid      = valid_q;
    assign bus.ball_y          = y_q;
    assign bus.ball_vy         = vy_q;
    assign bus.gravity_counter = gc_q;
    assign bus.is_collusion    = coll_out_q;
    assign bus.is_win          = win_out_q;
    assign bus.frame_err       = frame_err;
    assign bus.frame_drop      = overrun | timeout;
    assign bus.err_count       = err_q;
    assign bus.busy            = (state_q != StIdle);

endmodule
